register_write_scheduler: RTL
=============================

# register_write_scheduler

Write-port scheduler and hazard scoreboard for the 16-entry register bank. Merges the two writeback sources (single-cycle ALU result, variable-latency memory load) onto the bank's single write port (`writeEnabled`/`writeAddress`/`writeData`). Tracks which registers have a write in flight and stalls the issue stage on RAW/WAW hazards. Sits between decode/issue, the writeback paths and the register bank.

## Interface
- `REGS`, 16, number of architectural registers; index 15 is the PC.
- `ADDR_W`, 4, register address width.
- `DATA_W`, 32, register data width.
- `STARVE_LIMIT`, 4, cycles a buffered load may wait before the ALU is throttled (1..7).

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `issueValid`  in  1  issue stage presents an instruction.
- `issueWritesReg`  in  1  that instruction writes `issueDest`.
- `issueDest`  in  ADDR_W  destination register.
- `issueSrc1`, `issueSrc2`  in  ADDR_W  source registers.
- `issueStall`  out  1  hold the issue stage (combinational).
- `aluWbValid`  in  1  ALU writeback this cycle; cannot be back-pressured.
- `aluWbAddr`  in  ADDR_W ; `aluWbData`  in  DATA_W.
- `memWbValid`  in  1 ; `memWbReady`  out  1  load writeback handshake.
- `memWbAddr`  in  ADDR_W ; `memWbData`  in  DATA_W.
- `writeEnabled`  out  1 ; `writeAddress`  out  ADDR_W ; `writeData`  out  DATA_W  registered, to bank write port.
- `busyMask`  out  REGS  registered scoreboard, bit r = write to r in flight.

## Operation
- Load transfer occurs on a cycle with `memWbValid && memWbReady`. `memWbReady = !bufValid`.
- One-entry load buffer (`bufValid`, addr, data).
- Write-port priority each cycle: ALU > buffer > direct load.
  - ALU valid: ALU wins. A transferring load goes into the buffer.
  - ALU idle, buffer full: buffer drains. A new load cannot transfer because ready is 0.
  - ALU idle, buffer empty, load transferring: load goes straight to the port.
- Address 15: writebacks to 15 are dropped (`writeEnabled` stays 0, entry consumed). Issue with `issueDest`==15 never sets busy. Sources equal to 15 never stall.
- Scoreboard:
  - Set `busy[issueDest]` on an accepted issue (`issueValid && !issueStall && issueWritesReg`).
  - Clear `busy[writeAddress]` on each edge where registered `writeEnabled`==1. This is the edge on which the bank captures the data.
  - Same register set and cleared on one edge: set wins.
- `issueStall` = `issueValid` && (`busy[issueSrc1]` || `busy[issueSrc2]` || (`issueWritesReg` && `busy[issueDest]`) || `starve`).
- Starvation:
  - `starveCnt` (3 b) increments on each cycle with `bufValid && aluWbValid`, saturating at 7.
  - Clears on the edge the buffer drains.
  - `starve` = `starveCnt` >= `STARVE_LIMIT`. It stalls issue until the buffer drains; the ALU pipe then empties and the buffer wins the port.
- Two pending writes to one register cannot occur (WAW stall). If an upstream violation occurs, both writes are still performed in arbitration order.

## Timing
- Reset (async assert, sync-to-`clk` release):
  - `writeEnabled`=0, `writeAddress`=0, `writeData`=0, `busyMask`=0.
  - Buffer empty, `starveCnt`=0.
  - Hence `memWbReady`=1 and `issueStall`=0.
- Reset mid-operation discards the buffered load and all busy bits. The upstream pipeline is reset by the same signal.
- Latency: a write selected in cycle N appears on `writeEnabled`/`writeAddress`/`writeData` in N+1. The bank commits at the end of N+1. The busy bit clears at the same edge.
- The issue stage sees the released stall in N+2, when a bank read returns new data.
- Buffered load: minimum one extra cycle; maximum bounded by `STARVE_LIMIT` plus ALU pipe drain.
- `memWbReady` falls on the edge the buffer fills and rises on the edge it drains.

## Test plan
- Reset, then issue dest R3 and ALU writeback R3=0x1234 two cycles later:
  - `busyMask`=0x0008 after issue.
  - `writeEnabled`=1, `writeAddress`=3, `writeData`=0x1234 one cycle after the writeback.
  - `busyMask`=0 on the next edge.
- Issue src1=R3 while R3 busy -> `issueStall`=1 until the cycle after the bank write, then 0.
- ALU R1=0xA and load R2=0xB in the same cycle:
  - ALU R1 is written first.
  - `memWbReady`=0 for exactly 1 cycle.
  - R2=0xB is written the next cycle.
- Buffered load with `aluWbValid` held high, `STARVE_LIMIT`=4:
  - `issueStall` asserts on the 5th cycle of waiting.
  - Drop ALU valid -> buffer drains, stall releases, `starveCnt`=0.
- Writeback to R15 and issue with dest 15:
  - `writeEnabled` stays 0.
  - `busyMask` bit 15 never set.
  - No stall on src 15.
- Assert `rst` low with the buffer full and `busyMask`=0x00F0 -> outputs, mask and buffer clear immediately (asynchronously), and `memWbReady`=1.

Source files
------------

// File: rtl/register_write_scheduler.sv
// Write-port scheduler and hazard scoreboard for the register bank: merges ALU and
// load writebacks onto one write port and stalls issue on RAW/WAW hazards or load starvation.
module register_write_scheduler #(
    parameter int unsigned REGS         = 16,
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issueValid,
    input  logic              issueWritesReg,
    input  logic [ADDR_W-1:0] issueDest,
    input  logic [ADDR_W-1:0] issueSrc1,
    input  logic [ADDR_W-1:0] issueSrc2,
    output logic              issueStall,
    input  logic              aluWbValid,
    input  logic [ADDR_W-1:0] aluWbAddr,
    input  logic [DATA_W-1:0] aluWbData,
    input  logic              memWbValid,
    output logic              memWbReady,
    input  logic [ADDR_W-1:0] memWbAddr,
    input  logic [DATA_W-1:0] memWbData,
    output logic              writeEnabled,
    output logic [ADDR_W-1:0] writeAddress,
    output logic [DATA_W-1:0] writeData,
    output logic [REGS-1:0]   busyMask
);

    localparam int unsigned    CNT_W   = 3;
    localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(REGS - 1);

    logic              buf_valid, buf_valid_d;
    logic [ADDR_W-1:0] buf_addr, buf_addr_d;
    logic [DATA_W-1:0] buf_data, buf_data_d;
    logic [CNT_W-1:0]  starve_cnt, starve_cnt_d;
    logic [REGS-1:0]   busy_d;

    logic              mem_xfer;
    logic              starve;
    logic              issue_accept;
    logic              sel_valid;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              drain;
    logic              we_d;
    logic              src1_busy, src2_busy, dest_busy;

    // Handshake and hazard detection
    always_comb begin
        mem_xfer     = memWbValid && !buf_valid;
        memWbReady   = !buf_valid;
        starve       = starve_cnt >= CNT_W'(STARVE_LIMIT);
        src1_busy    = (issueSrc1 != PC_ADDR) && busyMask[issueSrc1];
        src2_busy    = (issueSrc2 != PC_ADDR) && busyMask[issueSrc2];
        dest_busy    = issueWritesReg && busyMask[issueDest];
        issueStall   = issueValid && (src1_busy || src2_busy || dest_busy || starve);
        issue_accept = issueValid && !issueStall && issueWritesReg;
    end

    // Port arbitration (ALU > buffer > direct load), buffer, starvation and scoreboard next state
    always_comb begin
        sel_valid    = 1'b0;
        sel_addr     = '0;
        sel_data     = '0;
        drain        = 1'b0;
        buf_valid_d  = buf_valid;
        buf_addr_d   = buf_addr;
        buf_data_d   = buf_data;
        starve_cnt_d = starve_cnt;
        busy_d       = busyMask;

        if (aluWbValid) begin
            sel_valid = 1'b1;
            sel_addr  = aluWbAddr;
            sel_data  = aluWbData;
            if (mem_xfer) begin
                buf_valid_d = 1'b1;
                buf_addr_d  = memWbAddr;
                buf_data_d  = memWbData;
            end
        end else if (buf_valid) begin
            sel_valid   = 1'b1;
            sel_addr    = buf_addr;
            sel_data    = buf_data;
            buf_valid_d = 1'b0;
            drain       = 1'b1;
        end else if (mem_xfer) begin
            sel_valid = 1'b1;
            sel_addr  = memWbAddr;
            sel_data  = memWbData;
        end

        // PC writebacks are consumed but never reach the bank
        we_d = sel_valid && (sel_addr != PC_ADDR);

        if (drain) begin
            starve_cnt_d = '0;
        end else if (buf_valid && aluWbValid && (starve_cnt != '1)) begin
            starve_cnt_d = starve_cnt + CNT_W'(1);
        end

        // Clear first so a same-edge set on the same register wins
        if (writeEnabled) begin
            busy_d[writeAddress] = 1'b0;
        end
        if (issue_accept && (issueDest != PC_ADDR)) begin
            busy_d[issueDest] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid    <= 1'b0;
            buf_addr     <= '0;
            buf_data     <= '0;
            starve_cnt   <= '0;
            busyMask     <= '0;
            writeEnabled <= 1'b0;
            writeAddress <= '0;
            writeData    <= '0;
        end else begin
            buf_valid    <= buf_valid_d;
            buf_addr     <= buf_addr_d;
            buf_data     <= buf_data_d;
            starve_cnt   <= starve_cnt_d;
            busyMask     <= busy_d;
            writeEnabled <= we_d;
            if (we_d) begin
                writeAddress <= sel_addr;
                writeData    <= sel_data;
            end
        end
    end

endmodule
